// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the execute
// stage and a secondary DMA/debug requester. The pipeline wins by default.
// A starvation counter forces a one-cycle pipeline stall (FORCE) so that a
// blocked DMA request is eventually served.
module dmem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        pipe_re,
  input  logic [3:0]  pipe_we,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_stall,
  input  logic        dma_req,
  input  logic [3:0]  dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FORCE = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               dma_rvalid_q;

  logic               pipe_active_s;
  logic               gnt_raw_s;
  logic [3:0]         we_raw_s;

  assign pipe_active_s = pipe_re | (pipe_we != 4'h0);

  // Port ownership mux: who drives the dmem address/data/byte-enables this cycle.
  always_comb begin
    mem_addr  = pipe_addr;
    mem_wdata = pipe_wdata;
    we_raw_s  = 4'h0;
    gnt_raw_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pipe_active_s) begin
          we_raw_s = pipe_we;
        end else if (dma_req) begin
          mem_addr  = dma_addr;
          mem_wdata = dma_wdata;
          we_raw_s  = dma_we;
          gnt_raw_s = 1'b1;
        end else begin
          we_raw_s = 4'h0;
        end
      end
      ST_FORCE: begin
        // Pipe writes are masked here; the stalled store is replayed next cycle.
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        if (dma_req) begin
          we_raw_s  = dma_we;
          gnt_raw_s = 1'b1;
        end else begin
          we_raw_s = 4'h0;
        end
      end
      default: begin
        we_raw_s  = 4'h0;
        gnt_raw_s = 1'b0;
      end
    endcase
  end

  // With the clock enable low nothing may commit: no grant, no write strobe.
  assign dma_gnt = gnt_raw_s & clk_en;
  assign mem_we  = clk_en ? we_raw_s : 4'h0;

  // Arbitration FSM, starvation counter and DMA read-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      dma_rvalid_q <= 1'b0;
    end else if (clk_en) begin
      dma_rvalid_q <= dma_gnt & (dma_we == 4'h0);
      case (state_q)
        ST_IDLE: begin
          if (dma_req & pipe_active_s) begin
            if (cnt_q == LIMIT_M1) begin
              state_q <= ST_FORCE;
              cnt_q   <= CNT_ZERO;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end else if (dma_gnt) begin
            cnt_q <= CNT_ZERO;
          end else begin
            // A dropped request keeps the accumulated count.
            cnt_q <= cnt_q;
          end
        end
        ST_FORCE: begin
          state_q <= ST_IDLE;
          cnt_q   <= CNT_ZERO;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= CNT_ZERO;
        end
      endcase
    end else begin
      state_q      <= state_q;
      cnt_q        <= cnt_q;
      dma_rvalid_q <= dma_rvalid_q;
    end
  end

  assign pipe_stall = (state_q == ST_FORCE);
  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rvalid_q ? mem_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter with a small synchronous dmem model.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        pipe_re;
  logic [3:0]  pipe_we;
  logic [31:0] pipe_addr;
  logic [31:0] pipe_wdata;
  logic        pipe_stall;
  logic        dma_req;
  logic [3:0]  dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];

  int total_cnt;
  int bad_cnt;

  dmem_port_arbiter #(.STARVE_LIMIT(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .pipe_re    (pipe_re),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_wdata (pipe_wdata),
    .pipe_stall (pipe_stall),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous dmem: byte-enabled write, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_we[0]) mem[mem_addr[9:2]][7:0]   <= mem_wdata[7:0];
    if (mem_we[1]) mem[mem_addr[9:2]][15:8]  <= mem_wdata[15:8];
    if (mem_we[2]) mem[mem_addr[9:2]][23:16] <= mem_wdata[23:16];
    if (mem_we[3]) mem[mem_addr[9:2]][31:24] <= mem_wdata[31:24];
    mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    mem[8'h80] = 32'h1234_5678;   // address 0x200
    mem_rdata  = 32'h0000_0000;
    rst_n      = 1'b0;
    clk_en     = 1'b1;
    pipe_re    = 1'b0;
    pipe_we    = 4'h0;
    pipe_addr  = 32'h0;
    pipe_wdata = 32'h0;
    dma_req    = 1'b0;
    dma_we     = 4'h0;
    dma_addr   = 32'h0;
    dma_wdata  = 32'h0;

    // Reset state
    #2;
    chk("rst_stall",  {31'b0, pipe_stall}, 32'h0);
    chk("rst_rvalid", {31'b0, dma_rvalid}, 32'h0);
    chk("rst_gnt",    {31'b0, dma_gnt},    32'h0);
    chk("rst_we",     {28'b0, mem_we},     32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // Pipe only: store to 0x100
    pipe_we = 4'hF; pipe_addr = 32'h100; pipe_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("pipe_we",    {28'b0, mem_we},     32'hF);
      chk("pipe_addr",  mem_addr,            32'h100);
      chk("pipe_gnt",   {31'b0, dma_gnt},    32'h0);
      chk("pipe_stall", {31'b0, pipe_stall}, 32'h0);
      tick();
    end

    // DMA only: read 0x200
    pipe_we = 4'h0;
    dma_req = 1'b1; dma_we = 4'h0; dma_addr = 32'h200;
    #2;
    chk("dma_gnt",  {31'b0, dma_gnt}, 32'h1);
    chk("dma_addr", mem_addr,         32'h200);
    chk("dma_rwe",  {28'b0, mem_we},  32'h0);
    tick();
    dma_req = 1'b0;
    #2;
    chk("dma_rvalid", {31'b0, dma_rvalid}, 32'h1);
    chk("dma_rdata",  dma_rdata,           32'h1234_5678);
    tick();
    #2;
    chk("dma_rvalid_off", {31'b0, dma_rvalid}, 32'h0);
    chk("dma_rdata_off",  dma_rdata,           32'h0);

    // Starvation: pipe reads 0x300, DMA read of 0x200 held
    tick();
    pipe_re = 1'b1; pipe_addr = 32'h300;
    dma_req = 1'b1; dma_we = 4'h0; dma_addr = 32'h200;
    for (int k = 1; k <= 8; k++) begin
      #2;
      chk("starve_gnt",   {31'b0, dma_gnt},    32'h0);
      chk("starve_stall", {31'b0, pipe_stall}, 32'h0);
      chk("starve_addr",  mem_addr,            32'h300);
      tick();
    end
    #2;
    chk("force_stall", {31'b0, pipe_stall}, 32'h1);
    chk("force_gnt",   {31'b0, dma_gnt},    32'h1);
    chk("force_addr",  mem_addr,            32'h200);
    tick();

    // Back in IDLE: pipe owns the port; new DMA write to set up masking test
    pipe_re = 1'b0; pipe_we = 4'h3; pipe_addr = 32'h300; pipe_wdata = 32'hAAAA_BBBB;
    dma_req = 1'b1; dma_we = 4'hC; dma_addr = 32'h304; dma_wdata = 32'h1122_3344;
    #2;
    chk("post_rvalid", {31'b0, dma_rvalid}, 32'h1);
    chk("post_rdata",  dma_rdata,           32'h1234_5678);
    chk("post_stall",  {31'b0, pipe_stall}, 32'h0);
    chk("post_addr",   mem_addr,            32'h300);
    for (int k = 1; k <= 8; k++) begin
      #2;
      chk("mask_pre_stall", {31'b0, pipe_stall}, 32'h0);
      chk("mask_pre_we",    {28'b0, mem_we},     32'h3);
      tick();
    end
    #2;
    chk("mask_we",    {28'b0, mem_we},     32'hC);
    chk("mask_addr",  mem_addr,            32'h304);
    chk("mask_wdata", mem_wdata,           32'h1122_3344);
    chk("mask_gnt",   {31'b0, dma_gnt},    32'h1);
    chk("mask_stall", {31'b0, pipe_stall}, 32'h1);
    tick();
    dma_req = 1'b0;
    #2;
    chk("replay_we",     {28'b0, mem_we},     32'h3);
    chk("replay_addr",   mem_addr,            32'h300);
    chk("replay_stall",  {31'b0, pipe_stall}, 32'h0);
    chk("replay_rvalid", {31'b0, dma_rvalid}, 32'h0);
    tick();

    // clk_en low during FORCE
    pipe_we = 4'h0; pipe_re = 1'b1; pipe_addr = 32'h300;
    dma_req = 1'b1; dma_we = 4'hF; dma_addr = 32'h308; dma_wdata = 32'hCAFE_F00D;
    for (int k = 1; k <= 8; k++) tick();
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("cen_stall", {31'b0, pipe_stall}, 32'h1);
      chk("cen_gnt",   {31'b0, dma_gnt},    32'h0);
      chk("cen_we",    {28'b0, mem_we},     32'h0);
      chk("cen_addr",  mem_addr,            32'h308);
      tick();
    end
    clk_en = 1'b1;
    #2;
    chk("cen_up_gnt",   {31'b0, dma_gnt},    32'h1);
    chk("cen_up_we",    {28'b0, mem_we},     32'hF);
    chk("cen_up_stall", {31'b0, pipe_stall}, 32'h1);
    tick();
    dma_req = 1'b0;
    #2;
    chk("cen_idle_stall",  {31'b0, pipe_stall}, 32'h0);
    chk("cen_idle_rvalid", {31'b0, dma_rvalid}, 32'h0);
    tick();

    // Back-to-back DMA reads verify everything written so far
    pipe_re = 1'b0;
    dma_req = 1'b1; dma_we = 4'h0; dma_addr = 32'h300;
    #2;
    chk("b2b_gnt0", {31'b0, dma_gnt}, 32'h1);
    tick();
    dma_addr = 32'h304;
    #2;
    chk("b2b_gnt1",  {31'b0, dma_gnt}, 32'h1);
    chk("b2b_rd300", dma_rdata,        32'h0000_BBBB);
    tick();
    dma_addr = 32'h308;
    #2;
    chk("b2b_rd304", dma_rdata, 32'h1122_0000);
    tick();
    dma_addr = 32'h100;
    #2;
    chk("b2b_rd308", dma_rdata, 32'hCAFE_F00D);
    tick();
    dma_req = 1'b0;
    #2;
    chk("b2b_rd100", dma_rdata, 32'hDEAD_BEEF);
    tick();

    // Async reset with a pending read response
    dma_req = 1'b1; dma_addr = 32'h200;
    tick();
    dma_req = 1'b0;
    #2;
    chk("arst_pre_rvalid", {31'b0, dma_rvalid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_rvalid", {31'b0, dma_rvalid}, 32'h0);
    chk("arst_rdata",  dma_rdata,           32'h0);
    chk("arst_stall",  {31'b0, pipe_stall}, 32'h0);
    tick();
    rst_n = 1'b1;

    // Dropped request keeps the count: 5 + (2 idle) + 3 blocked cycles -> FORCE
    pipe_re = 1'b1; pipe_addr = 32'h300;
    dma_req = 1'b1; dma_addr = 32'h200;
    for (int k = 0; k < 5; k++) tick();
    dma_req = 1'b0;
    tick(); tick();
    dma_req = 1'b1;
    tick(); tick();
    #2;
    chk("hold_stall7", {31'b0, pipe_stall}, 32'h0);
    tick();
    #2;
    chk("hold_force", {31'b0, pipe_stall}, 32'h1);
    chk("hold_gnt",   {31'b0, dma_gnt},    32'h1);
    // Async reset mid-FORCE clears state and count
    rst_n = 1'b0;
    #1;
    chk("frst_stall", {31'b0, pipe_stall}, 32'h0);
    chk("frst_gnt",   {31'b0, dma_gnt},    32'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      #2;
      chk("frst_cnt_stall", {31'b0, pipe_stall}, 32'h0);
    end
    tick();
    #2;
    chk("frst_force", {31'b0, pipe_stall}, 32'h1);
    tick();
    pipe_re = 1'b0; dma_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
